// File: rtl/wishbone_bus_if.sv
// Wishbone initiator bridging a CPU load/store port onto a single-beat
// classic Wishbone bus. Registered bus outputs, combinational CPU handshake,
// per-transaction timeout with a one-cycle err_o pulse.
module wishbone_bus_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;  // acked, holding data while pipeline stalls

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] addr_q, addr_d, wdat_q, wdat_d;
  logic        we_q, we_d, cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic        timeout;

  // cnt_q counts completed no-ack BUSY cycles; once it equals TIMEOUT_CYCLES
  // the current cycle is the abort cycle. Flush still wins (no err on flush),
  // and a late ack in the abort cycle is ignored so err and ack never pair up.
  assign timeout = (state_q == S_BUSY) && !flush_i && (cnt_q == TO_VAL);

  // Next-state and bus-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          wdat_d  = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i || timeout || wishbone_ack_i) begin
          // Every exit drops the whole bus so the next request gets a fresh edge
          addr_d  = '0;
          wdat_d  = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          cyc_d   = 1'b0;
          state_d = S_IDLE;
          if (flush_i)
            rbuf_d = '0;
          else if (!timeout) begin
            rbuf_d = wishbone_data_i;
            if (stall_i) state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          rbuf_d  = '0;
          state_d = S_IDLE;
        end else if (!stall_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CPU-side handshake: read data forwarded in the ack cycle with no extra latency
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    err_o      = 1'b0;
    case (state_q)
      S_IDLE: stallreq_o = cpu_ce_i & ~flush_i;
      S_BUSY: begin
        if (flush_i) begin
          stallreq_o = 1'b0;
        end else if (timeout) begin
          err_o = 1'b1;
        end else if (wishbone_ack_i) begin
          cpu_data_o = wishbone_data_i;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      S_WAIT:  cpu_data_o = rbuf_q;
      default: ;
    endcase
  end

  // State registers; async reset drops cyc/stb immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cyc_q   <= cyc_d;
    end
  end

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = wdat_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = cyc_q;
  assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Directed per-cycle vector bench for wishbone_bus_if (TIMEOUT_CYCLES=4),
// plus a hand sequence for asynchronous reset in the middle of a bus cycle.
module tb_wishbone_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce_i = 0, cpu_we_i = 0, stall_i = 0, flush_i = 0, ack = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, rdat = 0;
  logic [3:0]  cpu_sel_i = 0;
  logic [31:0] cpu_data_o, wb_addr, wb_data;
  logic        stallreq_o, err_o, wb_we, wb_stb, wb_cyc;
  logic [3:0]  wb_sel;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wishbone_bus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o), .err_o(err_o),
    .wishbone_addr_o(wb_addr), .wishbone_data_o(wb_data), .wishbone_we_o(wb_we),
    .wishbone_sel_o(wb_sel), .wishbone_stb_o(wb_stb), .wishbone_cyc_o(wb_cyc),
    .wishbone_data_i(rdat), .wishbone_ack_i(ack)
  );

  typedef struct {
    logic        rst, ce, we;
    logic [31:0] addr, wdat;
    logic [3:0]  sel;
    logic        stall, flush, ack;
    logic [31:0] rdat;
    logic        e_cyc;
    logic [31:0] e_addr, e_wdat;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_cdat;
    logic        e_sreq, e_err;
  } vec_t;

  localparam int NV = 39;
  vec_t tv [NV];

  function automatic vec_t v(
    logic r, logic ce, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
    logic st, logic fl, logic ak, logic [31:0] rd,
    logic ec, logic [31:0] ea, logic [31:0] ew, logic ewe, logic [3:0] es,
    logic [31:0] ecd, logic esr, logic eer);
    vec_t t;
    t.rst = r; t.ce = ce; t.we = we; t.addr = a; t.wdat = wd; t.sel = s;
    t.stall = st; t.flush = fl; t.ack = ak; t.rdat = rd;
    t.e_cyc = ec; t.e_addr = ea; t.e_wdat = ew; t.e_we = ewe; t.e_sel = es;
    t.e_cdat = ecd; t.e_sreq = esr; t.e_err = eer;
    return t;
  endfunction

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    // reset and idle
    tv[0]  = v(1,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    tv[1]  = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    // read 0x10, ack after 2 BUSY cycles
    tv[2]  = v(0,1,0,'h10,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[3]  = v(0,1,0,'h10,0,'hF, 0,0,0,0,       1,'h10,0,0,'hF, 0,1,0);
    tv[4]  = v(0,1,0,'h10,0,'hF, 0,0,0,0,       1,'h10,0,0,'hF, 0,1,0);
    tv[5]  = v(0,0,0,0,0,0, 0,0,1,'hDEADBEEF,   1,'h10,0,0,'hF, 'hDEADBEEF,0,0);
    tv[6]  = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    // write 0x20; CPU inputs change mid-cycle, bus must hold
    tv[7]  = v(0,1,1,'h20,'h12345678,'h3, 0,0,0,0, 0,0,0,0,0, 0,1,0);
    tv[8]  = v(0,1,1,'h20,'h12345678,'h3, 0,0,0,0, 1,'h20,'h12345678,1,'h3, 0,1,0);
    tv[9]  = v(0,0,0,'hFFFF,'hAAAAAAAA,'hF, 0,0,0,0, 1,'h20,'h12345678,1,'h3, 0,1,0);
    tv[10] = v(0,0,0,0,0,0, 0,0,1,0,            1,'h20,'h12345678,1,'h3, 0,0,0);
    tv[11] = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    // read back 0x20, responder returns the two written lanes
    tv[12] = v(0,1,0,'h20,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[13] = v(0,1,0,'h20,0,'hF, 0,0,1,'h5678,  1,'h20,0,0,'hF, 'h5678,0,0);
    // back-to-back: ce stays high, bus must go idle one cycle
    tv[14] = v(0,1,0,'h30,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[15] = v(0,1,0,'h30,0,'hF, 0,0,1,'h0BADF00D, 1,'h30,0,0,'hF, 'h0BADF00D,0,0);
    tv[16] = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    // ack under stall: data held in WAIT for 3 cycles
    tv[17] = v(0,1,0,'h40,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[18] = v(0,0,0,0,0,0, 1,0,1,'hCAFEBABE,   1,'h40,0,0,'hF, 'hCAFEBABE,0,0);
    tv[19] = v(0,0,0,0,0,0, 1,0,0,0,            0,0,0,0,0, 'hCAFEBABE,0,0);
    tv[20] = v(0,0,0,0,0,0, 1,0,0,0,            0,0,0,0,0, 'hCAFEBABE,0,0);
    tv[21] = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 'hCAFEBABE,0,0);
    tv[22] = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    // flush beats ack in BUSY
    tv[23] = v(0,1,0,'h50,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[24] = v(0,0,0,0,0,0, 0,0,0,0,            1,'h50,0,0,'hF, 0,1,0);
    tv[25] = v(0,0,0,0,0,0, 0,1,1,'h11111111,   1,'h50,0,0,'hF, 0,0,0);
    tv[26] = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);
    // flush in WAIT returns to IDLE despite stall, buffer cleared
    tv[27] = v(0,1,0,'h60,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[28] = v(0,0,0,0,0,0, 1,0,1,'h22222222,   1,'h60,0,0,'hF, 'h22222222,0,0);
    tv[29] = v(0,0,0,0,0,0, 1,1,0,0,            0,0,0,0,0, 'h22222222,0,0);
    tv[30] = v(0,0,0,0,0,0, 1,0,0,0,            0,0,0,0,0, 0,0,0);
    // flush blocks start in IDLE, then timeout after 4 no-ack BUSY cycles
    tv[31] = v(0,1,0,'h70,0,'hF, 0,1,0,0,       0,0,0,0,0, 0,0,0);
    tv[32] = v(0,1,0,'h70,0,'hF, 0,0,0,0,       0,0,0,0,0, 0,1,0);
    tv[33] = v(0,0,0,0,0,0, 0,0,0,0,            1,'h70,0,0,'hF, 0,1,0);
    tv[34] = v(0,0,0,0,0,0, 0,0,0,0,            1,'h70,0,0,'hF, 0,1,0);
    tv[35] = v(0,0,0,0,0,0, 0,0,0,0,            1,'h70,0,0,'hF, 0,1,0);
    tv[36] = v(0,0,0,0,0,0, 0,0,0,0,            1,'h70,0,0,'hF, 0,1,0);
    tv[37] = v(0,0,0,0,0,0, 0,0,0,0,            1,'h70,0,0,'hF, 0,0,1);
    tv[38] = v(0,0,0,0,0,0, 0,0,0,0,            0,0,0,0,0, 0,0,0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tv[i].rst; cpu_ce_i = tv[i].ce; cpu_we_i = tv[i].we;
      cpu_addr_i = tv[i].addr; cpu_data_i = tv[i].wdat; cpu_sel_i = tv[i].sel;
      stall_i = tv[i].stall; flush_i = tv[i].flush; ack = tv[i].ack; rdat = tv[i].rdat;
      #1;
      n_vec++;
      if (wb_cyc !== tv[i].e_cyc || wb_stb !== tv[i].e_cyc || wb_addr !== tv[i].e_addr ||
          wb_data !== tv[i].e_wdat || wb_we !== tv[i].e_we || wb_sel !== tv[i].e_sel ||
          cpu_data_o !== tv[i].e_cdat || stallreq_o !== tv[i].e_sreq || err_o !== tv[i].e_err) begin
        n_bad++;
        $display("FAIL vec%0d: got cyc=%b stb=%b addr=%h wd=%h we=%b sel=%h cd=%h sreq=%b err=%b; want cyc=%b addr=%h wd=%h we=%b sel=%h cd=%h sreq=%b err=%b",
                 i, wb_cyc, wb_stb, wb_addr, wb_data, wb_we, wb_sel, cpu_data_o, stallreq_o, err_o,
                 tv[i].e_cyc, tv[i].e_addr, tv[i].e_wdat, tv[i].e_we, tv[i].e_sel,
                 tv[i].e_cdat, tv[i].e_sreq, tv[i].e_err);
      end
    end

    // reset in the middle of a bus cycle: cyc/stb drop with no clock edge
    @(negedge clk);
    cpu_ce_i = 1; cpu_addr_i = 'h80; cpu_sel_i = 'hF;
    @(negedge clk);
    cpu_ce_i = 0;
    #1;
    check1("busy_before_rst_cyc", {31'd0, wb_cyc}, 32'd1);
    rst = 1;
    #1;
    check1("async_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check1("async_rst_stb", {31'd0, wb_stb}, 32'd0);
    check1("async_rst_addr", wb_addr, 32'd0);
    check1("async_rst_sel", {28'd0, wb_sel}, 32'd0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("post_rst_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    end
    cpu_ce_i = 1; cpu_addr_i = 'h90;
    @(negedge clk);
    cpu_ce_i = 0;
    #1;
    check1("post_rst_start_cyc", {31'd0, wb_cyc}, 32'd1);
    check1("post_rst_start_addr", wb_addr, 32'h90);
    check1("post_rst_start_sreq", {31'd0, stallreq_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wishbone_bus_if.md
WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of BUSY cycles without ack before a bus cycle is aborted (range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port cpu_ce_i, input, 1, CPU access request.
REQ-005 The block SHALL have port cpu_we_i, input, 1, CPU write enable.
REQ-006 The block SHALL have port cpu_addr_i, input, 32, CPU byte address.
REQ-007 The block SHALL have port cpu_data_i, input, 32, CPU write data.
REQ-008 The block SHALL have port cpu_sel_i, input, 4, CPU byte lane select.
REQ-009 The block SHALL have port stall_i, input, 1, pipeline stall from other stages.
REQ-010 The block SHALL have port flush_i, input, 1, pipeline flush.
REQ-011 The block SHALL have port cpu_data_o, output, 32, read data to CPU.
REQ-012 The block SHALL have port stallreq_o, output, 1, stall request to pipeline.
REQ-013 The block SHALL have port err_o, output, 1, one-cycle bus timeout pulse.
REQ-014 The block SHALL have ports wishbone_addr_o (32), wishbone_data_o (32), wishbone_we_o (1), wishbone_sel_o (4), wishbone_stb_o (1), wishbone_cyc_o (1), all outputs, Wishbone initiator signals.
REQ-015 The block SHALL have ports wishbone_data_i (32) and wishbone_ack_i (1), inputs, Wishbone responder signals.

Function
REQ-016 The block SHALL implement states IDLE, BUSY, WAIT_FOR_STALL; all wishbone_* outputs are registered.
REQ-017 In IDLE with cpu_ce_i=1 and flush_i=0, the block SHALL on the next edge drive stb=cyc=1, addr/data/we/sel from the cpu_* inputs, clear the timeout counter, and enter BUSY.
REQ-018 In IDLE, stallreq_o SHALL equal cpu_ce_i & ~flush_i (combinational) and cpu_data_o SHALL be 0.
REQ-019 In BUSY, all wishbone_* outputs SHALL hold stable until ack, flush or timeout.
REQ-020 In BUSY with wishbone_ack_i=1, the block SHALL: deassert stb, cyc, we, sel, addr, data to 0; latch wishbone_data_i into a read buffer; enter WAIT_FOR_STALL if stall_i=1, else IDLE.
REQ-021 In BUSY with ack=1, stallreq_o SHALL be 0 and cpu_data_o SHALL equal wishbone_data_i combinationally (zero extra latency); with ack=0, stallreq_o SHALL be 1 and cpu_data_o 0.
REQ-022 In BUSY, flush_i=1 SHALL take priority over ack: drop stb/cyc to 0, clear the read buffer, enter IDLE, no err_o.
REQ-023 In BUSY, the timeout counter SHALL increment each cycle without ack; when it reaches TIMEOUT_CYCLES, the block SHALL drop stb/cyc, pulse err_o for exactly one cycle, and enter IDLE, with stallreq_o=0 and cpu_data_o=0 during that cycle.
REQ-024 In WAIT_FOR_STALL, stallreq_o SHALL be 0 and cpu_data_o SHALL be the read buffer; the block SHALL return to IDLE when stall_i=0, or immediately on flush_i=1 (buffer cleared).
REQ-025 Every completed or aborted cycle SHALL leave cyc=stb=0 for at least one clock before the next cycle starts, giving responders a fresh request edge.
REQ-026 Write cycles SHALL follow the same flow; cpu_data_o carries whatever the responder returns and is don't-care to the CPU.
REQ-027 err_o and ack SHALL never be asserted for the same transaction.

Reset
REQ-028 While rst=1, the block SHALL be in IDLE with all wishbone_* outputs, read buffer, timeout counter and err_o at 0, independent of clk.
REQ-029 Reset asserted mid-BUSY SHALL drop cyc/stb to 0 immediately (asynchronously) and discard the transaction.

Verification
REQ-030 Read: cpu_ce_i=1, we=0, addr=0x0000_0010, sel=0xF, responder acks after 2 cycles with 0xDEAD_BEEF -> cyc/stb high 3 cycles, cpu_data_o=0xDEAD_BEEF in the ack cycle, stallreq_o high until the ack cycle.
REQ-031 Write: we=1, addr=0x20, data=0x1234_5678, sel=0x3 -> wishbone outputs carry these values stable until ack, then return to 0; a following read of 0x20 returns 0x0000_5678 through the responder.
REQ-032 Back-to-back: cpu_ce_i held high for two reads -> at least one cycle with cyc=0 between the two cycles.
REQ-033 Stall: ack with stall_i=1 for 3 cycles -> state WAIT_FOR_STALL, cpu_data_o holds the acked value for 3 cycles, stallreq_o=0, then IDLE.
REQ-034 Flush/timeout: flush_i=1 during BUSY -> cyc drops next edge, err_o=0; no ack with TIMEOUT_CYCLES=4 -> err_o pulses once after 4 BUSY cycles and cyc drops.
REQ-035 Reset: rst=1 mid-BUSY -> cyc/stb=0 without a clock edge; after release, stays in IDLE until cpu_ce_i=1.
